snn_reward_updater: RTL

Reward-modulated learning stage downstream of the multilayer SNN core. After an inference step, it takes the latched pre-synaptic and post-synaptic spike masks and a reward signal, then walks the 16-entry weight memory. For every synapse whose pre and post neurons both fired, it performs a saturating read-modify-write. It reaches memory through the same read-request/valid and writeback-request/ack handshakes the top-level arbiter already serves.

---
 rtl/snn_reward_updater.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/snn_reward_updater.sv
// Reward-modulated weight updater: walks the synapse memory after an inference step and applies a
// saturating +/-LR read-modify-write to every synapse whose pre and post neurons both spiked.
module snn_reward_updater #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DW     = 8,
  parameter int unsigned N_IN   = 4,
  parameter int unsigned N_OUT  = 4,
  parameter int unsigned LR     = 4,
  parameter int          W_MAX  = 127,
  parameter int          W_MIN  = -128
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [1:0]        i_reward,
  input  logic [N_IN-1:0]   i_pre_mask,
  input  logic [N_OUT-1:0]  i_post_mask,
  output logic              o_rd_req,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic              i_rd_valid,
  input  logic [DW-1:0]     i_rd_data,
  output logic              o_wb_req,
  output logic [ADDR_W-1:0] o_wb_addr,
  output logic [DW-1:0]     o_wb_data,
  input  logic              i_wb_ack,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W:0]   o_n_updates
);

  localparam int unsigned       NAddr    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LastAddr = '1;
  localparam logic signed [DW:0] LrExt   = (DW + 1)'(LR);
  localparam logic signed [DW:0] WMaxExt = (DW + 1)'(W_MAX);
  localparam logic signed [DW:0] WMinExt = (DW + 1)'(W_MIN);

  typedef enum logic [2:0] {StIdle, StScan, StRead, StModify, StWrite, StDone} state_e;

  state_e              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_idx;
  logic [N_IN-1:0]     r_pre;
  logic [N_OUT-1:0]    r_post;
  logic                r_punish;
  logic [DW-1:0]       r_w;
  logic [DW-1:0]       r_wb_data;
  logic [ADDR_W:0]     r_n_upd;

  logic [NAddr-1:0]    w_coinc_vec;
  logic                w_coinc;
  logic                w_last;
  logic signed [DW:0]  w_ext;
  logic signed [DW:0]  w_sum;
  logic [DW-1:0]       w_sat;

  // addr = out_idx*N_IN + in_idx
  for (genvar o = 0; o < N_OUT; o++) begin : g_out
    for (genvar i = 0; i < N_IN; i++) begin : g_in
      assign w_coinc_vec[o*N_IN+i] = r_pre[i] & r_post[o];
    end
  end

  assign w_coinc = w_coinc_vec[r_idx];
  assign w_last  = (r_idx == LastAddr);

  always_comb begin
    w_ext = {r_w[DW-1], r_w};
    w_sum = r_punish ? (w_ext - LrExt) : (w_ext + LrExt);
    if (w_sum > WMaxExt) begin
      w_sat = WMaxExt[DW-1:0];
    end else if (w_sum < WMinExt) begin
      w_sat = WMinExt[DW-1:0];
    end else begin
      w_sat = w_sum[DW-1:0];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle:   if (i_start) w_state_nxt = i_reward[0] ? StScan : StDone;
      StScan: begin
        if (w_coinc) begin
          w_state_nxt = StRead;
        end else if (w_last) begin
          w_state_nxt = StDone;
        end
      end
      StRead:   if (i_rd_valid) w_state_nxt = StModify;
      StModify: w_state_nxt = StWrite;
      StWrite:  if (i_wb_ack) w_state_nxt = w_last ? StDone : StScan;
      StDone:   w_state_nxt = StIdle;
      default:  w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx     <= '0;
      r_pre     <= '0;
      r_post    <= '0;
      r_punish  <= 1'b0;
      r_w       <= '0;
      r_wb_data <= '0;
      r_n_upd   <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (i_start) begin
            r_pre    <= i_pre_mask;
            r_post   <= i_post_mask;
            r_punish <= i_reward[1];
            r_n_upd  <= '0;
            r_idx    <= '0;
          end
        end
        StScan:   if (!w_coinc && !w_last) r_idx <= r_idx + ADDR_W'(1);
        StRead:   if (i_rd_valid) r_w <= i_rd_data;
        StModify: r_wb_data <= w_sat;
        StWrite: begin
          if (i_wb_ack) begin
            r_n_upd <= r_n_upd + (ADDR_W + 1)'(1);
            if (!w_last) r_idx <= r_idx + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_rd_req    = (r_state == StRead);
  assign o_wb_req    = (r_state == StWrite);
  assign o_rd_addr   = r_idx;
  assign o_wb_addr   = r_idx;
  assign o_wb_data   = r_wb_data;
  assign o_busy      = (r_state == StScan) || (r_state == StRead) ||
                       (r_state == StModify) || (r_state == StWrite);
  assign o_done      = (r_state == StDone);
  assign o_n_updates = r_n_upd;

endmodule
